// File: rtl/wb_data_bridge_pkg.sv
// Shared definitions for the pipelined Wishbone data bridge.
// Provides the bridge state encoding and the width helpers used by
// the top level and by the response ordering FIFO.
package wb_data_bridge_pkg;

  // Bridge state: IDLE (nothing in flight), BUSY (responses pending),
  // ABORT (timeout recovery, cycle dropped)
  typedef enum logic [1:0] {
    WBB_IDLE  = 2'd0,
    WBB_BUSY  = 2'd1,
    WBB_ABORT = 2'd2
  } wbb_state_e;

  // Byte-select width for a given data width
  function automatic int sel_width(input int data_width);
    return data_width / 8;
  endfunction

  // Bits needed to hold values 0..n (at least one bit)
  function automatic int cnt_width(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/wb_bridge_fifo.sv
// One-bit synchronous FIFO holding the is_read flag of every issued
// Wishbone request so that completions can be matched in issue order.
// Ports: clk_i, reset_i (sync, active-low), push/din (write side),
// pop/dout (read side, dout is the oldest entry), count/full/empty.
module wb_bridge_fifo
  import wb_data_bridge_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = cnt_width(DEPTH)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          push,
  input  logic          din,
  input  logic          pop,
  output logic          dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [DEPTH-1:0] mem_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;

  // Pointer advance with wrap at the last slot (depth need not be a power of two)
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? {PW{1'b0}} : p + PTR_ONE;
  endfunction

  // Storage, pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (pop) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == CNT_FULL);
  assign empty = (count_r == {CW{1'b0}});

  wb_bridge_fifo_chk u_chk (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push    (push),
    .pop     (pop),
    .full    (full),
    .empty   (empty)
  );

endmodule

// File: rtl/wb_bridge_fifo_chk.sv
// Simulation checker for the response ordering FIFO.
// Ports: clk_i/reset_i (sync, active-low), push/pop strobes and the
// full/empty flags of the FIFO under observation.
module wb_bridge_fifo_chk (
  input logic clk_i,
  input logic reset_i,
  input logic push,
  input logic pop,
  input logic full,
  input logic empty
);

  // The bridge never issues while the FIFO is full
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!reset_i) !(push && full));

  // The bridge never completes or drains a request that is not tracked
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!reset_i) !(pop && empty));

endmodule

// File: rtl/wb_data_bridge.sv
// Pipelined Wishbone B4 master bridge between the core data port and the
// system bus. Up to MAX_OUTSTANDING requests may be in flight; completions
// return to the core in issue order, one cycle after the bus response.
// A hung slave is detected by a per-response timeout and each lost
// request is reported to the core as one data_err_o pulse.
// Ports:
//   clk_i, reset_i (sync, active-low)
//   core side: data_req_i, data_wen_i (0 = write), data_addr_i, data_i,
//              data_wmask_i, data_stall_o, data_o, data_ack_o, data_err_o
//   bus side:  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
//              wb_stall_i, wb_ack_i, wb_err_i, wb_dat_i
module wb_data_bridge
  import wb_data_bridge_pkg::*;
#(
  parameter  int ADDR_WIDTH      = 32,
  parameter  int DATA_WIDTH      = 32,
  parameter  int MAX_OUTSTANDING = 2,
  parameter  int TIMEOUT_CYCLES  = 255,
  localparam int SEL_W           = sel_width(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  data_req_i,
  input  logic                  data_wen_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]      data_wmask_i,
  output logic                  data_stall_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_ack_o,
  output logic                  data_err_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic [SEL_W-1:0]      wb_sel_o,
  input  logic                  wb_stall_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic [DATA_WIDTH-1:0] wb_dat_i
);

  localparam int CW = cnt_width(MAX_OUTSTANDING);
  localparam int TW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [TW-1:0] TMR_ONE = TW'(1);
  localparam logic [TW-1:0] TMO_VAL = TW'(TIMEOUT_CYCLES);
  localparam logic          TMO_EN  = (TIMEOUT_CYCLES != 0);

  wbb_state_e            state_r, state_next;
  logic [CW-1:0]         count_r, count_next;
  logic [TW-1:0]         timer_r;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_full, fifo_empty, head_is_read;
  logic                  timeout_s, abort_s, issue_s, complete_s, drain_s, pop_s;
  logic                  ack_r, err_r;
  logic [DATA_WIDTH-1:0] rdata_r;

  // Timeout depends only on registered state, so a response arriving on the
  // expiry cycle is treated as lost rather than racing the abort.
  assign timeout_s = TMO_EN & (state_r == WBB_BUSY) & (timer_r == TMO_VAL);
  assign abort_s   = (state_r == WBB_ABORT) | timeout_s;

  // The FIFO tracks exactly the outstanding requests outside abort recovery,
  // so its full flag doubles as the issue limit.
  assign wb_stb_o     = data_req_i & ~abort_s & ~fifo_full;
  assign data_stall_o = data_req_i & (wb_stall_i | fifo_full | abort_s);
  assign wb_cyc_o     = wb_stb_o | (count_r != {CW{1'b0}});
  assign wb_we_o      = ~data_wen_i;
  assign wb_adr_o     = data_addr_i;
  assign wb_dat_o     = data_i;
  assign wb_sel_o     = data_wmask_i;

  assign issue_s    = wb_stb_o & ~wb_stall_i;
  assign complete_s = (wb_ack_i | wb_err_i) & wb_cyc_o & (count_r != {CW{1'b0}}) & ~abort_s;
  // During recovery each lost request is popped once, yielding one error pulse per cycle
  assign drain_s    = abort_s & ~fifo_empty;
  assign pop_s      = complete_s | drain_s;

  // Outstanding count update
  always_comb begin
    count_next = count_r;
    if (timeout_s) begin
      count_next = {CW{1'b0}};
    end else if (issue_s & ~complete_s) begin
      count_next = count_r + CNT_ONE;
    end else if (~issue_s & complete_s) begin
      count_next = count_r - CNT_ONE;
    end else begin
      count_next = count_r;
    end
  end

  // Next-state logic; ABORT lingers only while more than one lost request remains to drain
  always_comb begin
    state_next = state_r;
    case (state_r)
      WBB_IDLE: begin
        if (issue_s) state_next = WBB_BUSY;
        else         state_next = WBB_IDLE;
      end
      WBB_BUSY: begin
        if (timeout_s)                       state_next = WBB_ABORT;
        else if (count_next == {CW{1'b0}})   state_next = WBB_IDLE;
        else                                 state_next = WBB_BUSY;
      end
      WBB_ABORT: begin
        if (fifo_count > CNT_ONE) state_next = WBB_ABORT;
        else                      state_next = WBB_IDLE;
      end
      default: state_next = WBB_IDLE;
    endcase
  end

  // State, outstanding count and response timer
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_r <= WBB_IDLE;
      count_r <= {CW{1'b0}};
      timer_r <= {TW{1'b0}};
    end else begin
      state_r <= state_next;
      count_r <= count_next;
      if ((state_r == WBB_BUSY) && !complete_s && !timeout_s) begin
        timer_r <= timer_r + TMR_ONE;
      end else begin
        timer_r <= {TW{1'b0}};
      end
    end
  end

  // Registered completion pulses and read data capture
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= {DATA_WIDTH{1'b0}};
    end else begin
      ack_r <= complete_s & ~wb_err_i;
      err_r <= (complete_s & wb_err_i) | drain_s;
      if (complete_s && !wb_err_i && head_is_read) begin
        rdata_r <= wb_dat_i;
      end
    end
  end

  assign data_ack_o = ack_r;
  assign data_err_o = err_r;
  assign data_o     = rdata_r;

  wb_bridge_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push    (issue_s),
    .din     (data_wen_i),
    .pop     (pop_s),
    .dout    (head_is_read),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_wb_data_bridge.sv
// Self-checking bench for wb_data_bridge (MAX_OUTSTANDING=2, TIMEOUT_CYCLES=8).
// A per-cycle vector table covers reset, a single read, pipelined writes with
// back-pressure, an error completion and ignored stray responses; hand-written
// sequences cover bus stall, timeout recovery and reset with requests in flight.
module tb_wb_data_bridge;

  logic        clk;
  logic        reset_i;
  logic        data_req_i;
  logic        data_wen_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_i;
  logic [3:0]  data_wmask_i;
  logic        data_stall_o;
  logic [31:0] data_o;
  logic        data_ack_o;
  logic        data_err_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stall_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic [31:0] wb_dat_i;

  int pass_cnt  = 0;
  int total_cnt = 0;

  wb_data_bridge #(
    .ADDR_WIDTH      (32),
    .DATA_WIDTH      (32),
    .MAX_OUTSTANDING (2),
    .TIMEOUT_CYCLES  (8)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .data_req_i   (data_req_i),
    .data_wen_i   (data_wen_i),
    .data_addr_i  (data_addr_i),
    .data_i       (data_i),
    .data_wmask_i (data_wmask_i),
    .data_stall_o (data_stall_o),
    .data_o       (data_o),
    .data_ack_o   (data_ack_o),
    .data_err_o   (data_err_o),
    .wb_cyc_o     (wb_cyc_o),
    .wb_stb_o     (wb_stb_o),
    .wb_we_o      (wb_we_o),
    .wb_adr_o     (wb_adr_o),
    .wb_dat_o     (wb_dat_o),
    .wb_sel_o     (wb_sel_o),
    .wb_stall_i   (wb_stall_i),
    .wb_ack_i     (wb_ack_i),
    .wb_err_i     (wb_err_i),
    .wb_dat_i     (wb_dat_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        req;
    logic        wen;
    logic [31:0] addr;
    logic        stall;
    logic        ack;
    logic        err;
    logic [31:0] rdat;
    logic        chk;
    logic        e_stall;
    logic        e_stb;
    logic        e_cyc;
    logic        e_we;
    logic        e_ack;
    logic        e_err;
    logic        chk_data;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[27];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic drive(input logic req, input logic wen, input logic [31:0] addr,
                       input logic stall, input logic ack, input logic err,
                       input logic [31:0] rdat);
    data_req_i  = req;
    data_wen_i  = wen;
    data_addr_i = addr;
    data_i      = addr ^ 32'h5A5A_0000;
    wb_stall_i  = stall;
    wb_ack_i    = ack;
    wb_err_i    = err;
    wb_dat_i    = rdat;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic rst, input logic req, input logic wen,
                              input logic [31:0] addr, input logic stall, input logic ack,
                              input logic err, input logic [31:0] rdat, input logic chk,
                              input logic e_stall, input logic e_stb, input logic e_cyc,
                              input logic e_we, input logic e_ack, input logic e_err,
                              input logic chk_data, input logic [31:0] e_data);
    vec_t v;
    v.rst = rst; v.req = req; v.wen = wen; v.addr = addr; v.stall = stall;
    v.ack = ack; v.err = err; v.rdat = rdat; v.chk = chk; v.e_stall = e_stall;
    v.e_stb = e_stb; v.e_cyc = e_cyc; v.e_we = e_we; v.e_ack = e_ack;
    v.e_err = e_err; v.chk_data = chk_data; v.e_data = e_data;
    return v;
  endfunction

  initial begin
    reset_i      = 1'b0;
    data_wmask_i = 4'hF;
    drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    //              rst  req  wen  addr          stl  ack  err  rdat          chk  stl  stb  cyc  we   ack  err  cd   data
    vecs[0]  = mk(1'b0,1'b0,1'b1,32'h0000_0000,1'b0,1'b0,1'b0,32'h0000_0000, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0);
    vecs[1]  = mk(1'b0,1'b0,1'b1,32'h0000_0000,1'b0,1'b0,1'b0,32'h0000_0000, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0);
    vecs[2]  = mk(1'b1,1'b0,1'b1,32'h0000_0000,1'b0,1'b0,1'b0,32'h0000_0000, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0);
    // single read to 0x100, acked one cycle after issue
    vecs[3]  = mk(1'b1,1'b1,1'b1,32'h0000_0100,1'b0,1'b0,1'b0,32'h0000_0000, 1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0);
    vecs[4]  = mk(1'b1,1'b0,1'b1,32'h0000_0000,1'b0,1'b1,1'b0,32'hDEAD_BEEF, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0);
    vecs[5]  = mk(1'b1,1'b0,1'b1,32'h0000_0000,1'b0,1'b0,1'b0,32'h0000_0000, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,32'hDEAD_BEEF);
    vecs[6]  = mk(1'b1,1'b0,1'b1,32'h0000_0000,1'b0,1'b0,1'b0,32'h0000_0000, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,32'hDEAD_BEEF);
    // writes 0x0, 0x4, 0x8; acks three cycles after each issue
    vecs[7]  = mk(1'b1,1'b1,1'b0,32'h0000_0000,1'b0,1'b0,1'b0,32'h0000_0000, 1'b1,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,32'h0);
    vecs[8]  = mk(1'b1,1'b1,1'b0,32'h0000_0004,1'b0,1'b0,1'b0,32'h0000_0000, 1'b1,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,32'h0);
    vecs[9]  = mk(1'b1,1'b1,1'b0,32'h0000_0008,1'b0,1'b0,1'b0,32'h0000_0000, 1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,32'h0);
    vecs[10] = mk(1'b1,1'b1,1'b0,32'h0000_0008,1'b0,1'b1,1'b0,32'h0000_0000, 1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,32'h0);
    vecs[11] = mk(1'b1,1'b1,1'b0,32'h0000_0008,1'b0,1'b1,1'b0,32'h0000_0000, 1'b1,1'b0,1'b1,1'b1,1'b1,1'b1,1'b0,1'b0,32'h0);
    vecs[12] = mk(1'b1,1'b0,1'b1,32'h0000_0000,1'b0,1'b0,1'b0,32'h0000_0000, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,32'h0);
    vecs[13] = mk(1'b1,1'b0,1'b1,32'h0000_0000,1'b0,1'b0,1'b0,32'h0000_0000, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0);
    vecs[14] = mk(1'b1,1'b0,1'b1,32'h0000_0000,1'b0,1'b1,1'b0,32'h0000_0000, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0);
    vecs[15] = mk(1'b1,1'b0,1'b1,32'h0000_0000,1'b0,1'b0,1'b0,32'h0000_0000, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,32'hDEAD_BEEF);
    vecs[16] = mk(1'b1,1'b0,1'b1,32'h0000_0000,1'b0,1'b0,1'b0,32'h0000_0000, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0);
    // two reads; the second completes with a slave error
    vecs[17] = mk(1'b1,1'b1,1'b1,32'h0000_0200,1'b0,1'b0,1'b0,32'h0000_0000, 1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0);
    vecs[18] = mk(1'b1,1'b1,1'b1,32'h0000_0204,1'b0,1'b0,1'b0,32'h0000_0000, 1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0);
    vecs[19] = mk(1'b1,1'b0,1'b1,32'h0000_0000,1'b0,1'b1,1'b0,32'h1111_2222, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0);
    vecs[20] = mk(1'b1,1'b0,1'b1,32'h0000_0000,1'b0,1'b0,1'b1,32'h0BAD_0BAD, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,32'h1111_2222);
    vecs[21] = mk(1'b1,1'b0,1'b1,32'h0000_0000,1'b0,1'b0,1'b0,32'h0000_0000, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,32'h1111_2222);
    // stray response with nothing outstanding is ignored
    vecs[22] = mk(1'b1,1'b0,1'b1,32'h0000_0000,1'b0,1'b1,1'b1,32'h7777_7777, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,32'h0);
    vecs[23] = mk(1'b1,1'b0,1'b1,32'h0000_0000,1'b0,1'b0,1'b0,32'h0000_0000, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,32'h1111_2222);
    // ack and err together: error wins, read data not captured
    vecs[24] = mk(1'b1,1'b1,1'b1,32'h0000_0208,1'b0,1'b0,1'b0,32'h0000_0000, 1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0);
    vecs[25] = mk(1'b1,1'b0,1'b1,32'h0000_0000,1'b0,1'b1,1'b1,32'h5555_5555, 1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'h0);
    vecs[26] = mk(1'b1,1'b0,1'b1,32'h0000_0000,1'b0,1'b0,1'b0,32'h0000_0000, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,32'h1111_2222);

    step();
    for (int i = 0; i < 27; i++) begin
      reset_i = vecs[i].rst;
      drive(vecs[i].req, vecs[i].wen, vecs[i].addr, vecs[i].stall,
            vecs[i].ack, vecs[i].err, vecs[i].rdat);
      #1;
      if (vecs[i].chk) begin
        check($sformatf("row%0d data_stall", i), {31'd0, data_stall_o}, {31'd0, vecs[i].e_stall});
        check($sformatf("row%0d stb", i),        {31'd0, wb_stb_o},     {31'd0, vecs[i].e_stb});
        check($sformatf("row%0d cyc", i),        {31'd0, wb_cyc_o},     {31'd0, vecs[i].e_cyc});
        check($sformatf("row%0d we", i),         {31'd0, wb_we_o},      {31'd0, vecs[i].e_we});
        check($sformatf("row%0d data_ack", i),   {31'd0, data_ack_o},   {31'd0, vecs[i].e_ack});
        check($sformatf("row%0d data_err", i),   {31'd0, data_err_o},   {31'd0, vecs[i].e_err});
        if (vecs[i].chk_data) begin
          check($sformatf("row%0d data_o", i), data_o, vecs[i].e_data);
        end
      end
      step();
    end

    // Slave stalls for four cycles: request held, nothing counted as issued
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 32'h0000_0300, 1'b1, 1'b0, 1'b0, 32'h0);
      #1;
      check($sformatf("stall%0d stb", k),        {31'd0, wb_stb_o},     32'd1);
      check($sformatf("stall%0d data_stall", k), {31'd0, data_stall_o}, 32'd1);
      check($sformatf("stall%0d adr", k),        wb_adr_o,              32'h0000_0300);
      check($sformatf("stall%0d sel", k),        {28'd0, wb_sel_o},     32'h0000_000F);
      step();
    end
    drive(1'b1, 1'b1, 32'h0000_0300, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    check("stall_release data_stall", {31'd0, data_stall_o}, 32'd0);
    step();
    drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 32'hCAFE_F00D);
    #1;
    step();
    drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    check("stall_done ack",  {31'd0, data_ack_o}, 32'd1);
    check("stall_done data", data_o,              32'hCAFE_F00D);
    check("stall_done cyc",  {31'd0, wb_cyc_o},   32'd0);
    step();

    // Two reads never answered: timeout after 8 waiting cycles
    drive(1'b1, 1'b1, 32'h0000_0400, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    check("tmo issue0 stb", {31'd0, wb_stb_o}, 32'd1);
    step();
    drive(1'b1, 1'b1, 32'h0000_0404, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    check("tmo issue1 stb", {31'd0, wb_stb_o}, 32'd1);
    step();
    drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int k = 2; k <= 8; k++) begin
      #1;
      check($sformatf("tmo wait%0d cyc", k), {31'd0, wb_cyc_o},   32'd1);
      check($sformatf("tmo wait%0d err", k), {31'd0, data_err_o}, 32'd0);
      step();
    end
    drive(1'b1, 1'b1, 32'h0000_0500, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    check("tmo fire data_stall", {31'd0, data_stall_o}, 32'd1);
    check("tmo fire stb",        {31'd0, wb_stb_o},     32'd0);
    check("tmo fire cyc",        {31'd0, wb_cyc_o},     32'd1);
    check("tmo fire err",        {31'd0, data_err_o},   32'd0);
    step();
    #1;
    check("tmo abort cyc",        {31'd0, wb_cyc_o},     32'd0);
    check("tmo abort stb",        {31'd0, wb_stb_o},     32'd0);
    check("tmo abort data_stall", {31'd0, data_stall_o}, 32'd1);
    check("tmo abort err1",       {31'd0, data_err_o},   32'd1);
    step();
    #1;
    check("tmo recover err2",       {31'd0, data_err_o},   32'd1);
    check("tmo recover stb",        {31'd0, wb_stb_o},     32'd1);
    check("tmo recover data_stall", {31'd0, data_stall_o}, 32'd0);
    check("tmo recover cyc",        {31'd0, wb_cyc_o},     32'd1);
    step();
    drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 32'h600D_F00D);
    #1;
    check("tmo fresh err_clear", {31'd0, data_err_o}, 32'd0);
    check("tmo fresh cyc",       {31'd0, wb_cyc_o},   32'd1);
    step();
    drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    check("tmo fresh ack",  {31'd0, data_ack_o}, 32'd1);
    check("tmo fresh data", data_o,              32'h600D_F00D);
    check("tmo fresh cyc2", {31'd0, wb_cyc_o},   32'd0);
    step();

    // Reset with two requests in flight, then a late ack
    drive(1'b1, 1'b1, 32'h0000_0700, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    drive(1'b1, 1'b1, 32'h0000_0704, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    reset_i = 1'b0;
    drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    reset_i = 1'b1;
    drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 32'h1234_5678);
    #1;
    check("rst cyc", {31'd0, wb_cyc_o},   32'd0);
    check("rst ack", {31'd0, data_ack_o}, 32'd0);
    check("rst err", {31'd0, data_err_o}, 32'd0);
    step();
    drive(1'b1, 1'b1, 32'h0000_0708, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    check("rst late_ack ignored", {31'd0, data_ack_o}, 32'd0);
    check("rst late_err ignored", {31'd0, data_err_o}, 32'd0);
    check("rst new stb",          {31'd0, wb_stb_o},   32'd1);
    step();
    drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0F0F_0F0F);
    step();
    drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    check("rst new ack",  {31'd0, data_ack_o}, 32'd1);
    check("rst new data", data_o,              32'h0F0F_0F0F);
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
